pergate_gatefn_seq: RTL and testbench
=====================================

// Module: pergate_gatefn_seq
// PURPOSE
//  Sequences one shared pergate_compute_gatefn_early unit over NGROUPS batches of NCORE gates.
//  Per batch it: fetches operands, pulses the unit's en, waits for ready, and emits the NCORE results.
//  Sits between the layer operand buffer and the per-gate accumulator in the prover layer pipeline.
// PARAMETERS
//  NCORE    4   gates evaluated per unit invocation (matches unit array depth)
//  NGROUPS  8   batches per run; group index width GW = $clog2(NGROUPS), min 1
//  (field width is the global `F_NBITS macro, not a parameter)
// PORTS
//  clk         in   1              clock
//  rstb        in   1              async active-low reset
//  start       in   1              begin run; sampled only in IDLE
//  abort       in   1              sync abort, any state -> IDLE
//  mux_sel_in  in   1              mux_sel for the run, latched at start
//  z1_chi_in   in   F_NBITS        chi(z1) for the run, latched at start
//  busy        out  1              high in every state except IDLE
//  done        out  1              1-cycle pulse after last group written
//  op_req      out  1              operand request, held until op_valid
//  op_addr     out  GW             group index being fetched
//  op_valid    in   1              operands present on op_in0/op_in1 this cycle
//  op_in0      in   NCORE*F_NBITS  packed in0[k] at [k*F_NBITS +: F_NBITS]
//  op_in1      in   NCORE*F_NBITS  packed in1[k], same packing
//  fn_en       out  1              1-cycle start pulse to the unit
//  fn_mux_sel  out  1              latched mux_sel_in
//  fn_z1_chi   out  F_NBITS        latched z1_chi_in
//  fn_in0      out  NCORE*F_NBITS  latched operands, stable from LAUNCH until result accepted
//  fn_in1      out  NCORE*F_NBITS
//  fn_ready    in   1              unit ready (level)
//  fn_out      in   NCORE*F_NBITS  unit gatefn results
//  res_valid   out  1              result valid, held until res_ack
//  res_addr    out  GW             group index of res_data
//  res_data    out  NCORE*F_NBITS  captured fn_out
//  res_ack     in   1              consumer accepts result when res_valid & res_ack
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; group counter 0.
//  Reset: operand/result/config regs 0; ready_dly = 1 (no spurious edge out of reset).
//  Edge detect: rdy_edge = fn_ready & ~ready_dly; ready_dly <= fn_ready every cycle.
//  Edge detect: edges outside WAIT are ignored.
//  FSM states: IDLE -> FETCH -> LAUNCH -> WAIT -> WRITE -> {FETCH | DONE}, then DONE -> IDLE.
//   IDLE:   on start, latch z1_chi_in/mux_sel_in, grp=0 -> FETCH; start while busy ignored.
//   FETCH:  op_req=1, op_addr=grp; on op_valid latch op_in0/op_in1 -> LAUNCH.
//   LAUNCH: fn_en=1 for exactly one cycle -> WAIT.
//   WAIT:   on rdy_edge capture fn_out into res_data -> WRITE.
//           A ready level already high on entry is not completion.
//   WRITE:  res_valid=1, res_addr=grp, res_data stable.
//           On res_ack: if grp==NGROUPS-1 -> DONE; else grp<=grp+1 -> FETCH.
//   DONE:   done=1 one cycle, busy=1 -> IDLE.
//  Latency per group with op_valid and res_ack immediate:
//   FETCH(1) + LAUNCH(1) + unit latency L + WRITE(1) cycles.
//  Run total: NGROUPS*(L+3)+1 cycles.
//  No field arithmetic here; counter compare only, no wrap (run ends at NGROUPS-1).
//  abort: next cycle IDLE, op_req/fn_en/res_valid drop, done not pulsed, grp=0.
//  abort: an in-flight unit computation is left to finish and its ready edge ignored.
//  abort has priority over start, op_valid, rdy_edge and res_ack in the same cycle.
//  Async reset mid-run: everything returns to reset values immediately.
//  op_valid outside FETCH and res_ack outside WRITE are ignored.
// STRUCTURE
//  pergate_seq_pkg: state enum (IDLE,FETCH,LAUNCH,WAIT,WRITE,DONE), GW helper function, packing macros.
//  Sub-module pergate_ready_edge: ready_dly reg + rising-edge output, reset value 1.
//  Top level: FSM, group counter, operand/result latches.
// TESTING  (bench instantiates the real unit with gate_fn=`GATEFN_MUL; p = 2^61-1)
//  1. NGROUPS=1, z1_chi=5, in0[k]=2, in1[k]=3, op_valid/res_ack immediate:
//     -> res_data[k]=30, done after L+4 cycles.
//  2. NGROUPS=8, random operands, res_ack tied 1:
//     -> 8 results with res_addr 0..7 in order, each = z1*in0*in1 mod p.
//     -> exactly 8 fn_en pulses and 1 done pulse.
//  3. op_valid delayed 5 cycles and res_ack delayed 3 cycles per group:
//     -> op_req/res_valid held, fn_in* and res_data stable, results unchanged.
//  4. fn_ready held high before LAUNCH:
//     -> no completion until the unit drops and re-raises ready; no early res_valid.
//  5. abort asserted in WAIT of group 2, then start again:
//     -> IDLE next cycle, no done pulse, new run restarts at op_addr 0, stale ready edge ignored.
//  6. rstb pulsed low during WRITE, and start pulsed while busy:
//     -> outputs 0 immediately on reset; start while busy has no effect on grp or the latched z1_chi.

Source files
------------

// File: rtl/pergate_seq_pkg.sv
// pergate_seq_pkg: shared state encoding, group-width helper
// and lane packing helpers for the gatefn sequencer.
`ifndef F_NBITS
`define F_NBITS 64
`endif

`define PG_LANE(v, k) v[(k)*`F_NBITS +: `F_NBITS]

package pergate_seq_pkg;

  localparam int FW = `F_NBITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic int grp_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pergate_ready_edge.sv
// pergate_ready_edge: rising-edge detect on the unit ready level.
// Delay reg resets high so reset release never looks like an edge.
module pergate_ready_edge (
  input  logic clk,
  input  logic rstb,
  input  logic ready,
  output logic rise
);

  logic ready_dly;

  // remember last cycle's ready level
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) ready_dly <= 1'b1;
    else       ready_dly <= ready;
  end

  assign rise = ready & ~ready_dly;

endmodule

// File: rtl/pergate_gatefn_seq.sv
// pergate_gatefn_seq: runs one shared gatefn unit over NGROUPS
// batches of NCORE gates: fetch, launch, wait, write back.
module pergate_gatefn_seq
  import pergate_seq_pkg::*;
#(
  parameter int NCORE   = 4,
  parameter int NGROUPS = 8,
  localparam int GW = grp_w(NGROUPS),
  localparam int DW = NCORE * FW
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic          abort,
  input  logic          mux_sel_in,
  input  logic [FW-1:0] z1_chi_in,
  output logic          busy,
  output logic          done,
  output logic          op_req,
  output logic [GW-1:0] op_addr,
  input  logic          op_valid,
  input  logic [DW-1:0] op_in0,
  input  logic [DW-1:0] op_in1,
  output logic          fn_en,
  output logic          fn_mux_sel,
  output logic [FW-1:0] fn_z1_chi,
  output logic [DW-1:0] fn_in0,
  output logic [DW-1:0] fn_in1,
  input  logic          fn_ready,
  input  logic [DW-1:0] fn_out,
  output logic          res_valid,
  output logic [GW-1:0] res_addr,
  output logic [DW-1:0] res_data,
  input  logic          res_ack
);

  localparam logic [GW-1:0] LAST = GW'(NGROUPS - 1);

  state_t        state;
  logic [GW-1:0] grp;
  logic          rdy_edge;

  pergate_ready_edge u_edge (
    .clk   (clk),
    .rstb  (rstb),
    .ready (fn_ready),
    .rise  (rdy_edge)
  );

  assign op_addr  = grp;
  assign res_addr = grp;

  // sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= S_IDLE;
      grp        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_req     <= 1'b0;
      fn_en      <= 1'b0;
      res_valid  <= 1'b0;
      fn_mux_sel <= 1'b0;
      fn_z1_chi  <= '0;
      fn_in0     <= '0;
      fn_in1     <= '0;
      res_data   <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      grp       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_req    <= 1'b0;
      fn_en     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      fn_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            fn_z1_chi  <= z1_chi_in;
            fn_mux_sel <= mux_sel_in;
            grp        <= '0;
            busy       <= 1'b1;
            op_req     <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (op_valid) begin
            fn_in0 <= op_in0;
            fn_in1 <= op_in1;
            op_req <= 1'b0;
            fn_en  <= 1'b1;
            state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (rdy_edge) begin
            res_data  <= fn_out;
            res_valid <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            if (grp == LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              grp    <= grp + 1'b1;
              op_req <= 1'b1;
              state  <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pergate_gatefn_seq.sv
// tb_pergate_gatefn_seq: directed bench with a behavioural
// GATEFN_MUL unit model (latency L, p = 2^61-1).
module tb_pergate_gatefn_seq;
  import pergate_seq_pkg::*;

  localparam int NCORE = 4;
  localparam int NG    = 8;
  localparam int GW    = 3;
  localparam int DW    = NCORE * FW;
  localparam int L     = 4;
  localparam logic [FW-1:0] P = 64'h1FFF_FFFF_FFFF_FFFF;
  localparam logic [FW-1:0] JUNK = 64'hA5A5_5A5A_A5A5_5A5A;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] e;
  } vec_t;

  logic          clk, rstb, start, abort, mux_sel_in;
  logic [FW-1:0] z1_chi_in;
  logic          busy, done, op_req, op_valid;
  logic [GW-1:0] op_addr, res_addr;
  logic [DW-1:0] op_in0, op_in1, fn_in0, fn_in1;
  logic [DW-1:0] fn_out, res_data;
  logic          fn_en, fn_mux_sel, fn_ready;
  logic [FW-1:0] fn_z1_chi;
  logic          res_valid, res_ack;

  pergate_gatefn_seq #(.NCORE(NCORE), .NGROUPS(NG)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort),
    .mux_sel_in(mux_sel_in), .z1_chi_in(z1_chi_in),
    .busy(busy), .done(done),
    .op_req(op_req), .op_addr(op_addr), .op_valid(op_valid),
    .op_in0(op_in0), .op_in1(op_in1),
    .fn_en(fn_en), .fn_mux_sel(fn_mux_sel),
    .fn_z1_chi(fn_z1_chi), .fn_in0(fn_in0), .fn_in1(fn_in1),
    .fn_ready(fn_ready), .fn_out(fn_out),
    .res_valid(res_valid), .res_addr(res_addr),
    .res_data(res_data), .res_ack(res_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // unit model
  function automatic logic [FW-1:0] mulmod(
    input logic [FW-1:0] x, input logic [FW-1:0] y);
    logic [2*FW-1:0] t;
    t = ({{FW{1'b0}}, x} * {{FW{1'b0}}, y}) % {{FW{1'b0}}, P};
    return t[FW-1:0];
  endfunction

  function automatic logic [DW-1:0] unit_fn(
    input logic [FW-1:0] z, input logic [DW-1:0] a,
    input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int k = 0; k < NCORE; k++)
      `PG_LANE(r, k) = mulmod(mulmod(z, `PG_LANE(a, k)),
                              `PG_LANE(b, k));
    return r;
  endfunction

  bit            u_lag = 1'b0;
  logic [3:0]    u_cnt = '0;
  logic [DW-1:0] u_res = '0;

  always @(posedge clk) begin
    if (fn_en) begin
      u_cnt <= 4'(L + int'(u_lag));
      u_res <= unit_fn(fn_z1_chi, fn_in0, fn_in1);
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1'b1;
    end
  end

  assign fn_ready = (u_cnt <= 1) || (u_lag && u_cnt == 4'(L + 1));
  assign fn_out   = (u_cnt <= 1) ? u_res : {NCORE{JUNK}};

  // operand source / result sink
  logic [DW-1:0] run_a [NG];
  logic [DW-1:0] run_b [NG];
  logic [DW-1:0] run_e [NG];
  int op_delay = 0, ack_delay = 0, op_cnt = 0, ack_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (op_req) begin
      op_valid = (op_cnt >= op_delay);
      op_cnt++;
    end else begin
      op_valid = 1'b0;
      op_cnt = 0;
    end
    op_in0 = op_valid ? run_a[op_addr] : {NCORE{JUNK}};
    op_in1 = op_valid ? run_b[op_addr] : {NCORE{~JUNK}};
    if (res_valid) begin
      res_ack = (ack_cnt >= ack_delay);
      ack_cnt++;
    end else begin
      res_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  // monitor
  logic [GW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  int            q_cyc[$];
  int n_en = 0, n_done = 0, done_cyc = 0, stab_err = 0;
  bit stab_on = 1'b0;
  logic p_rv = 0, p_ack = 0, p_req = 0, p_opv = 0;
  logic [DW-1:0] p_data = '0;
  logic [GW-1:0] p_addr = '0;

  always @(negedge clk) begin
    if (fn_en) n_en++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (res_valid && res_ack) begin
      q_addr.push_back(res_addr);
      q_data.push_back(res_data);
      q_cyc.push_back(cyc);
    end
    if (stab_on) begin
      if (p_rv && !p_ack && (!res_valid || res_data !== p_data
          || res_addr !== p_addr)) stab_err++;
      if (p_req && !p_opv && !op_req) stab_err++;
      if (res_valid && fn_in0 !== run_a[res_addr]) stab_err++;
      if (res_valid && fn_in1 !== run_b[res_addr]) stab_err++;
    end
    p_rv = res_valid; p_ack = res_ack; p_data = res_data;
    p_addr = res_addr; p_req = op_req; p_opv = op_valid;
  end

  // checking helpers
  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  function automatic logic [DW-1:0] lanes(
    input logic [FW-1:0] l0, input logic [FW-1:0] l1,
    input logic [FW-1:0] l2, input logic [FW-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic start_pulse(input logic [FW-1:0] z,
                             input logic m, output int t0);
    z1_chi_in = z;
    mux_sel_in = m;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = done;
    end
    if (!hit) timeout(nm);
    @(posedge clk) #1;
  endtask

  task automatic wait_grp(input bit wr, input int g, input string nm);
    bit hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = wr ? (res_valid && res_addr == GW'(g))
               : (fn_en && op_addr == GW'(g));
    end
    if (!hit) timeout(nm);
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_cnt"}, DW'(q_data.size()), DW'(NG));
    for (int i = 0; i < NG && i < q_data.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), DW'(q_addr[i]), DW'(i));
      chk($sformatf("%s_d%0d", tag, i), q_data[i], run_e[i]);
    end
  endtask

  task automatic clr_q();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  vec_t tbl [NG];

  task automatic load_tbl();
    for (int g = 0; g < NG; g++) begin
      run_a[g] = tbl[g].a;
      run_b[g] = tbl[g].b;
      run_e[g] = tbl[g].e;
    end
  endtask

  task automatic load_flat(input logic [FW-1:0] a,
                           input logic [FW-1:0] b,
                           input logic [FW-1:0] e);
    for (int g = 0; g < NG; g++) begin
      run_a[g] = {NCORE{a}};
      run_b[g] = {NCORE{b}};
      run_e[g] = {NCORE{e}};
    end
  endtask

  int t0, en0, dn0;

  initial begin
    // z1 = 3 for every table run
    tbl[0] = '{lanes(1, 2, 3, 4), lanes(1, 1, 1, 1),
               lanes(3, 6, 9, 12)};
    tbl[1] = '{lanes(5, 6, 7, 8), lanes(2, 2, 2, 2),
               lanes(30, 36, 42, 48)};
    tbl[2] = '{lanes(10, 0, 1, 100), lanes(10, 5, 0, 100),
               lanes(300, 0, 0, 30000)};
    tbl[3] = '{lanes(P - 1, P - 1, 1, 2), lanes(1, P - 1, P - 1, 0),
               lanes(P - 3, 3, P - 3, 0)};
    tbl[4] = '{lanes(64'h1_0000_0000, 7, 9, 11),
               lanes(64'h1_0000_0000, 1, 1, 1),
               lanes(24, 21, 27, 33)};
    tbl[5] = '{lanes(64'h1000_0000_0000_0000, 13, 14, 15),
               lanes(2, 3, 3, 3), lanes(3, 117, 126, 135)};
    tbl[6] = '{lanes(1, 1, 1, 1), lanes(1000, 2000, 3000, 4000),
               lanes(3000, 6000, 9000, 12000)};
    tbl[7] = '{lanes(P - 2, 20, 21, 22), lanes(P - 2, 1, 1, 1),
               lanes(12, 60, 63, 66)};

    rstb = 1'b1; start = 1'b0; abort = 1'b0;
    mux_sel_in = 1'b0; z1_chi_in = '0;
    op_valid = 1'b0; res_ack = 1'b0;
    op_in0 = '0; op_in1 = '0;
    #3 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_opreq", DW'(op_req), 0);
    chk("rst_fnen", DW'(fn_en), 0);
    chk("rst_rv", DW'(res_valid), 0);
    chk("rst_addr", DW'(op_addr), 0);
    rstb = 1'b1;
    @(posedge clk) #1;

    // 1: flat operands, timing of first result and done
    load_flat(2, 3, 30);
    clr_q();
    en0 = n_en; dn0 = n_done;
    start_pulse(5, 1'b1, t0);
    chk("t1_busy", DW'(busy), 1);
    wait_done("t1_done");
    chk_run("t1");
    chk("t1_lat", DW'(q_cyc[0] - t0), DW'(L + 3));
    chk("t1_run", DW'(done_cyc - t0), DW'(NG * (L + 3) + 1));
    chk("t1_en", DW'(n_en - en0), DW'(NG));
    chk("t1_dn", DW'(n_done - dn0), 1);
    chk("t1_mux", DW'(fn_mux_sel), 1);
    chk("t1_idle", DW'(busy), 0);

    // 2: table run incl. modular wrap lanes
    load_tbl();
    clr_q();
    en0 = n_en; dn0 = n_done;
    start_pulse(3, 1'b0, t0);
    wait_done("t2_done");
    chk_run("t2");
    chk("t2_en", DW'(n_en - en0), DW'(NG));
    chk("t2_dn", DW'(n_done - dn0), 1);
    chk("t2_mux", DW'(fn_mux_sel), 0);

    // 3: slow operand source and slow consumer
    op_delay = 5; ack_delay = 3;
    stab_on = 1'b1;
    clr_q();
    start_pulse(3, 1'b0, t0);
    wait_done("t3_done");
    stab_on = 1'b0;
    chk_run("t3");
    chk("t3_run", DW'(done_cyc - t0), DW'(NG * (L + 3 + 8) + 1));
    chk("t3_stab", DW'(stab_err), 0);
    op_delay = 0; ack_delay = 0;

    // 4: ready still high after launch is not completion
    u_lag = 1'b1;
    clr_q();
    start_pulse(3, 1'b0, t0);
    wait_done("t4_done");
    chk_run("t4");
    chk("t4_lat", DW'(q_cyc[0] - t0), DW'(L + 4));
    chk("t4_run", DW'(done_cyc - t0), DW'(NG * (L + 4) + 1));
    u_lag = 1'b0;

    // 5: abort in WAIT of group 2, then restart
    dn0 = n_done;
    start_pulse(3, 1'b0, t0);
    wait_grp(1'b0, 2, "t5_launch2");
    @(posedge clk) #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk) #1;
    abort = 1'b0;
    start = 1'b0;
    op_delay = 5;
    chk("t5_busy", DW'(busy), 0);
    chk("t5_opreq", DW'(op_req), 0);
    chk("t5_rv", DW'(res_valid), 0);
    chk("t5_addr", DW'(op_addr), 0);
    clr_q();
    start_pulse(3, 1'b0, t0);
    chk("t5_raddr", DW'(op_addr), 0);
    wait_done("t5_done");
    chk_run("t5");
    chk("t5_dn", DW'(n_done - dn0), 1);
    op_delay = 0;

    // 6: start while busy, then async reset in WRITE
    ack_delay = 3;
    load_flat(1, 1, 7);
    clr_q();
    start_pulse(7, 1'b1, t0);
    wait_grp(1'b0, 1, "t6_launch1");
    @(posedge clk) #1;
    z1_chi_in = 9;
    mux_sel_in = 1'b0;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    chk("t6_z1", DW'(fn_z1_chi), 7);
    chk("t6_mux", DW'(fn_mux_sel), 1);
    chk("t6_grp", DW'(op_addr), 1);
    chk("t6_busy", DW'(busy), 1);
    wait_grp(1'b1, 1, "t6_write1");
    rstb = 1'b0;
    #1;
    chk("t6r_busy", DW'(busy), 0);
    chk("t6r_rv", DW'(res_valid), 0);
    chk("t6r_data", res_data, 0);
    chk("t6r_z1", DW'(fn_z1_chi), 0);
    chk("t6r_opreq", DW'(op_req), 0);
    chk("t6r_in0", fn_in0, 0);
    chk("t6r_addr", DW'(res_addr), 0);
    chk("t6_qn", DW'(q_data.size()), 1);
    if (q_data.size() > 0)
      chk("t6_d0", q_data[0], {NCORE{64'd7}});
    @(posedge clk) #1;
    rstb = 1'b1;
    ack_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle", DW'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
